// File: rtl/draw_pkg.sv
// Shared types and default dimensions for the cube-demo draw sequencer.
package draw_pkg;

    // Sequencer phases, in the order a redraw walks through them.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LOAD  = 3'd2,
        ST_START = 3'd3,
        ST_DRAW  = 3'd4,
        ST_DONE  = 3'd5
    } draw_state_t;

    // Default framebuffer geometry and pixel colour width.
    localparam int DRAW_FB_WIDTH  = 32;
    localparam int DRAW_FB_HEIGHT = 32;
    localparam int DRAW_COLORW    = 3;

endpackage

// File: rtl/draw_sequencer_clear_scanner.sv
// Raster x/y counter that walks every framebuffer pixel once during the clear pass.
module clear_scanner
    import draw_pkg::*;
#(
    parameter int FB_WIDTH  = DRAW_FB_WIDTH,
    parameter int FB_HEIGHT = DRAW_FB_HEIGHT,
    parameter int XY_BITW   = 11
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_en,
    input  logic               i_restart,
    output logic [XY_BITW-1:0] o_cx,
    output logic [XY_BITW-1:0] o_cy,
    output logic               o_last
);

    logic [XY_BITW-1:0] r_cx;
    logic [XY_BITW-1:0] r_cy;
    logic               w_x_end;
    logic               w_y_end;

    assign w_x_end = (r_cx == XY_BITW'(FB_WIDTH - 1));
    assign w_y_end = (r_cy == XY_BITW'(FB_HEIGHT - 1));

    // Advance x every enabled cycle; x wraps into a y step at the end of a row.
    always_ff @(posedge i_clk) begin
        // NOTE: flops use non-blocking assignments so every register samples
        // pre-edge values regardless of statement order.
        if (!i_rst || i_restart) begin
            r_cx <= '0;
            r_cy <= '0;
        end else if (i_en) begin
            if (w_x_end) begin
                r_cx <= '0;
                r_cy <= w_y_end ? '0 : r_cy + 1'b1;
            end else begin
                r_cx <= r_cx + 1'b1;
            end
        end
    end

    assign o_cx   = r_cx;
    assign o_cy   = r_cy;
    assign o_last = w_x_end && w_y_end;

endmodule

// File: rtl/draw_sequencer.sv
// Frame-synchronised controller: clears the framebuffer, sequences every cube
// line through the line drawer, then hands the address bus to scan-out.
module draw_sequencer
    import draw_pkg::*;
#(
    parameter int XY_BITW      = 11,
    parameter int LINEW        = 4,
    parameter int LINE_CNT     = 12,
    parameter int COLORW       = DRAW_COLORW,
    parameter int FB_WIDTH     = DRAW_FB_WIDTH,
    parameter int FB_HEIGHT    = DRAW_FB_HEIGHT,
    parameter int CLEAR_COLOR  = 0,
    parameter int GC_LAT       = 1,
    parameter int DRAW_TIMEOUT = 4096
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_frame,
    input  logic               i_redraw,
    input  logic [XY_BITW-1:0] i_sx,
    input  logic [XY_BITW-1:0] i_sy,
    input  logic [COLORW-1:0]  i_cube_color,
    output logic [LINEW-1:0]   o_line_id,
    output logic               o_dl_start,
    output logic               o_dl_oe,
    input  logic [XY_BITW-1:0] i_dl_x,
    input  logic [XY_BITW-1:0] i_dl_y,
    input  logic               i_dl_drawing,
    input  logic               i_dl_done,
    output logic               o_fb_we,
    output logic [XY_BITW-1:0] o_fb_x,
    output logic [XY_BITW-1:0] o_fb_y,
    output logic [COLORW-1:0]  o_fb_color,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err
);

    localparam int TO_W  = (DRAW_TIMEOUT > 1) ? $clog2(DRAW_TIMEOUT) : 1;
    localparam int LAT_W = $clog2(GC_LAT + 1);

    draw_state_t        r_state;
    logic [LINEW-1:0]   r_line_id;
    logic [TO_W-1:0]    r_to_cnt;
    logic [LAT_W-1:0]   r_lat_cnt;
    logic               r_pending;
    logic               r_err;

    logic [XY_BITW-1:0] w_cx;
    logic [XY_BITW-1:0] w_cy;
    logic               w_last;
    logic               w_scan_en;
    logic               w_scan_restart;
    logic               w_timeout;
    logic               w_last_line;

    assign w_scan_en      = (r_state == ST_CLEAR);
    assign w_scan_restart = (r_state == ST_IDLE) && i_frame;
    assign w_timeout      = (r_to_cnt == TO_W'(DRAW_TIMEOUT - 1));
    assign w_last_line    = (r_line_id == LINEW'(LINE_CNT - 1));

    clear_scanner #(
        .FB_WIDTH  (FB_WIDTH),
        .FB_HEIGHT (FB_HEIGHT),
        .XY_BITW   (XY_BITW)
    ) u_clear_scanner (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_en      (w_scan_en),
        .i_restart (w_scan_restart),
        .o_cx      (w_cx),
        .o_cy      (w_cy),
        .o_last    (w_last)
    );

    // Sequencer FSM with its line index, settle/timeout counters and sticky flags.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state   <= ST_IDLE;
            r_line_id <= '0;
            r_to_cnt  <= '0;
            r_lat_cnt <= '0;
            r_pending <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            // A redraw request is remembered from any state; DONE consumes it.
            if (i_redraw) begin
                r_pending <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (i_frame) begin
                        r_state <= ST_CLEAR;
                    end
                end

                ST_CLEAR: begin
                    if (w_last) begin
                        r_line_id <= '0;
                        r_lat_cnt <= '0;
                        r_state   <= ST_LOAD;
                    end
                end

                // Give the line generator GC_LAT cycles to settle on line_id.
                ST_LOAD: begin
                    if (r_lat_cnt == LAT_W'(GC_LAT - 1)) begin
                        r_state <= ST_START;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 1'b1;
                    end
                end

                ST_START: begin
                    r_to_cnt <= '0;
                    r_state  <= ST_DRAW;
                end

                // A timeout is treated exactly like completion, plus a sticky error.
                ST_DRAW: begin
                    if (i_dl_done || w_timeout) begin
                        if (!i_dl_done) begin
                            r_err <= 1'b1;
                        end
                        if (w_last_line) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_line_id <= r_line_id + 1'b1;
                            r_lat_cnt <= '0;
                            r_state   <= ST_LOAD;
                        end
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end

                ST_DONE: begin
                    if (r_pending) begin
                        r_pending <= 1'b0;
                        r_line_id <= '0;
                        r_state   <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Framebuffer port mux and status decode, combinational from state and inputs.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned and infers a latch.
        o_fb_we    = 1'b0;
        o_fb_x     = '0;
        o_fb_y     = '0;
        o_fb_color = '0;
        o_dl_start = 1'b0;
        o_dl_oe    = (r_state != ST_DONE);
        o_busy     = 1'b0;
        o_done     = 1'b0;

        case (r_state)
            ST_CLEAR: begin
                o_fb_we    = 1'b1;
                o_fb_x     = w_cx;
                o_fb_y     = w_cy;
                o_fb_color = COLORW'(CLEAR_COLOR);
                o_busy     = 1'b1;
            end
            ST_LOAD: begin
                o_busy = 1'b1;
            end
            ST_START: begin
                o_dl_start = 1'b1;
                o_busy     = 1'b1;
            end
            ST_DRAW: begin
                o_fb_we    = i_dl_drawing;
                o_fb_x     = i_dl_x;
                o_fb_y     = i_dl_y;
                o_fb_color = i_cube_color;
                o_busy     = 1'b1;
            end
            ST_DONE: begin
                o_fb_x = i_sx;
                o_fb_y = i_sy;
                o_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign o_line_id = r_line_id;
    assign o_err     = r_err;

endmodule

// File: tb/tb_draw_sequencer.sv
// Directed bench for draw_sequencer: 4x4 framebuffer, 3 lines, GC_LAT = 1,
// DRAW_TIMEOUT = 16.
module tb_draw_sequencer;

    localparam int XY_BITW = 11;
    localparam int LINEW   = 4;
    localparam int COLORW  = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               frame;
    logic               redraw;
    logic [XY_BITW-1:0] sx;
    logic [XY_BITW-1:0] sy;
    logic [COLORW-1:0]  cube_color;
    logic [LINEW-1:0]   line_id;
    logic               dl_start;
    logic               dl_oe;
    logic [XY_BITW-1:0] dl_x;
    logic [XY_BITW-1:0] dl_y;
    logic               dl_drawing;
    logic               dl_done;
    logic               fb_we;
    logic [XY_BITW-1:0] fb_x;
    logic [XY_BITW-1:0] fb_y;
    logic [COLORW-1:0]  fb_color;
    logic               busy;
    logic               done;
    logic               err;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    draw_sequencer #(
        .XY_BITW      (XY_BITW),
        .LINEW        (LINEW),
        .LINE_CNT     (3),
        .COLORW       (COLORW),
        .FB_WIDTH     (4),
        .FB_HEIGHT    (4),
        .CLEAR_COLOR  (0),
        .GC_LAT       (1),
        .DRAW_TIMEOUT (16)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_frame      (frame),
        .i_redraw     (redraw),
        .i_sx         (sx),
        .i_sy         (sy),
        .i_cube_color (cube_color),
        .o_line_id    (line_id),
        .o_dl_start   (dl_start),
        .o_dl_oe      (dl_oe),
        .i_dl_x       (dl_x),
        .i_dl_y       (dl_y),
        .i_dl_drawing (dl_drawing),
        .i_dl_done    (dl_done),
        .o_fb_we      (fb_we),
        .o_fb_x       (fb_x),
        .o_fb_y       (fb_y),
        .o_fb_color   (fb_color),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Step to just after the next rising edge; inputs driven here are stable
    // well before the following edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle on freshly driven inputs before sampling.
    task automatic settle();
        #1;
    endtask

    // Model drawer: five pixels for the given line, dl_done on the fifth.
    task automatic draw_ok(input int line, input bit poke_frame);
        for (int j = 0; j < 5; j++) begin
            dl_drawing = 1'b1;
            dl_x       = XY_BITW'(10 + j);
            dl_y       = XY_BITW'(20 + line);
            dl_done    = (j == 4);
            frame      = poke_frame && (j == 2);
            settle();
            check($sformatf("l%0d_we%0d", line, j), 32'(fb_we), 32'd1);
            check($sformatf("l%0d_x%0d", line, j), 32'(fb_x), 32'(10 + j));
            check($sformatf("l%0d_y%0d", line, j), 32'(fb_y), 32'(20 + line));
            check($sformatf("l%0d_col%0d", line, j), 32'(fb_color), 32'd5);
            check($sformatf("l%0d_id%0d", line, j), 32'(line_id), 32'(line));
            cyc();
        end
        dl_drawing = 1'b0;
        dl_done    = 1'b0;
        frame      = 1'b0;
    endtask

    initial begin
        rst        = 1'b0;
        frame      = 1'b0;
        redraw     = 1'b0;
        sx         = '0;
        sy         = '0;
        cube_color = 3'd5;
        dl_x       = '0;
        dl_y       = '0;
        dl_drawing = 1'b0;
        dl_done    = 1'b0;

        // Reset state.
        cyc();
        cyc();
        rst = 1'b1;
        settle();
        check("rst_we", 32'(fb_we), 32'd0);
        check("rst_start", 32'(dl_start), 32'd0);
        check("rst_oe", 32'(dl_oe), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_fbx", 32'(fb_x), 32'd0);
        check("rst_fby", 32'(fb_y), 32'd0);
        check("rst_col", 32'(fb_color), 32'd0);
        check("rst_id", 32'(line_id), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        // Frame pulse, then a 16-cycle clear pass in raster order; a redraw
        // request arrives mid-clear.
        cyc();
        frame = 1'b1;
        settle();
        check("idle_busy", 32'(busy), 32'd0);
        cyc();
        frame = 1'b0;
        for (int k = 0; k < 16; k++) begin
            redraw = (k == 5);
            settle();
            check($sformatf("clr_we%0d", k), 32'(fb_we), 32'd1);
            check($sformatf("clr_x%0d", k), 32'(fb_x), 32'(k % 4));
            check($sformatf("clr_y%0d", k), 32'(fb_y), 32'(k / 4));
            check($sformatf("clr_col%0d", k), 32'(fb_color), 32'd0);
            check($sformatf("clr_busy%0d", k), 32'(busy), 32'd1);
            cyc();
        end
        redraw = 1'b0;

        // 17th cycle is LOAD, then START.
        settle();
        check("load0_we", 32'(fb_we), 32'd0);
        check("load0_start", 32'(dl_start), 32'd0);
        check("load0_busy", 32'(busy), 32'd1);
        cyc();
        settle();
        check("start0", 32'(dl_start), 32'd1);
        check("start0_id", 32'(line_id), 32'd0);
        cyc();

        // Line 0 draws normally; a frame pulse in DRAW must be ignored.
        draw_ok(0, 1'b1);
        settle();
        check("load1_start", 32'(dl_start), 32'd0);
        check("load1_we", 32'(fb_we), 32'd0);
        check("load1_id", 32'(line_id), 32'd1);
        cyc();
        settle();
        check("start1", 32'(dl_start), 32'd1);
        cyc();

        // Line 1 never completes: exactly 16 DRAW cycles, then timeout.
        for (int j = 0; j < 16; j++) begin
            dl_drawing = 1'b1;
            dl_x       = XY_BITW'(j);
            dl_y       = XY_BITW'(1);
            settle();
            check($sformatf("to_we%0d", j), 32'(fb_we), 32'd1);
            check($sformatf("to_err%0d", j), 32'(err), 32'd0);
            check($sformatf("to_id%0d", j), 32'(line_id), 32'd1);
            cyc();
        end
        settle();
        check("to_load_we", 32'(fb_we), 32'd0);
        check("to_err", 32'(err), 32'd1);
        check("to_id", 32'(line_id), 32'd2);
        dl_drawing = 1'b0;
        cyc();
        settle();
        check("start2", 32'(dl_start), 32'd1);
        cyc();

        // Last line, then DONE with the scan-out coordinates on the bus.
        draw_ok(2, 1'b0);
        sx         = XY_BITW'(7);
        sy         = XY_BITW'(3);
        dl_drawing = 1'b1;
        settle();
        check("done_done", 32'(done), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        check("done_oe", 32'(dl_oe), 32'd0);
        check("done_we", 32'(fb_we), 32'd0);
        check("done_fbx", 32'(fb_x), 32'd7);
        check("done_fby", 32'(fb_y), 32'd3);

        // Pending redraw: one cycle in DONE, then IDLE with line_id cleared.
        cyc();
        dl_drawing = 1'b0;
        settle();
        check("idle2_done", 32'(done), 32'd0);
        check("idle2_oe", 32'(dl_oe), 32'd1);
        check("idle2_id", 32'(line_id), 32'd0);
        check("idle2_fbx", 32'(fb_x), 32'd0);
        check("idle2_err", 32'(err), 32'd1);

        // Next frame restarts the clear pass from (0,0).
        frame = 1'b1;
        cyc();
        frame = 1'b0;
        settle();
        check("clr2_busy", 32'(busy), 32'd1);
        check("clr2_we", 32'(fb_we), 32'd1);
        check("clr2_x", 32'(fb_x), 32'd0);
        check("clr2_y", 32'(fb_y), 32'd0);
        check("clr2_id", 32'(line_id), 32'd0);
        for (int k = 0; k < 18; k++) begin
            cyc();
        end

        // Now in DRAW of line 0; reset for one cycle mid-line.
        dl_drawing = 1'b1;
        dl_x       = XY_BITW'(2);
        dl_y       = XY_BITW'(2);
        settle();
        check("pre_rst_we", 32'(fb_we), 32'd1);
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        settle();
        check("mid_rst_we", 32'(fb_we), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_id", 32'(line_id), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        check("mid_rst_oe", 32'(dl_oe), 32'd1);
        for (int k = 0; k < 5; k++) begin
            cyc();
            dl_done = (k == 2);
            settle();
            check($sformatf("idle3_we%0d", k), 32'(fb_we), 32'd0);
            check($sformatf("idle3_busy%0d", k), 32'(busy), 32'd0);
        end
        dl_done    = 1'b0;
        dl_drawing = 1'b0;

        // Only a new frame leaves IDLE.
        frame = 1'b1;
        cyc();
        frame = 1'b0;
        settle();
        check("clr3_busy", 32'(busy), 32'd1);
        check("clr3_we", 32'(fb_we), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
